// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// seq_restoring_divider : restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro SIGNED_DIV_EN selects two's-complement operands.  Rev 1.0
// ============================================================================
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_qreg;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_dividend;
  logic             r_dz;
  logic             w_accept;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_q_res;
  logic [WIDTH-1:0] w_r_res;
`ifdef SIGNED_DIV_EN
  logic             r_neg_q;
  logic             r_neg_r;
`endif

  // A new request is taken in IDLE and also in DONE, which allows back-to-back ops.
  assign w_accept = start && (r_state != RUN);
  assign busy     = (r_state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) w_next = (divisor == '0) ? DONE : RUN;
        else       w_next = IDLE;
      end
      RUN:     if (r_cnt == CNT_W'(1)) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_mag_a = dividend;
    w_mag_b = divisor;
`ifdef SIGNED_DIV_EN
    if (dividend[WIDTH-1]) w_mag_a = -dividend;
    if (divisor[WIDTH-1])  w_mag_b = -divisor;
`endif
  end

  // The stored partial remainder is always below the divisor, so its top bit
  // of the (WIDTH+1)-bit working value is implicitly zero and not kept.
  assign w_shift = {r_rem, r_qreg[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_divisor};

  always_comb begin
    w_q_res = r_qreg;
    w_r_res = r_rem;
`ifdef SIGNED_DIV_EN
    if (r_neg_q) w_q_res = -r_qreg;
    if (r_neg_r) w_r_res = -r_rem;
`endif
    if (r_dz) begin
      w_q_res = '1;
      w_r_res = r_dividend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_qreg      <= '0;
      r_divisor   <= '0;
      r_dividend  <= '0;
      r_dz        <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (r_state == DONE) begin
        done        <= 1'b1;
        quotient    <= w_q_res;
        remainder   <= w_r_res;
        div_by_zero <= r_dz;
      end
      if (w_accept) begin
        r_rem      <= '0;
        r_qreg     <= w_mag_a;
        r_divisor  <= w_mag_b;
        r_dividend <= dividend;
        r_dz       <= (divisor == '0);
        r_cnt      <= CNT_W'(WIDTH);
`ifdef SIGNED_DIV_EN
        r_neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        r_neg_r    <= dividend[WIDTH-1];
`endif
      end else if (r_state == RUN) begin
        r_rem  <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
        r_qreg <= {r_qreg[WIDTH-2:0], ~w_trial[WIDTH]};
        r_cnt  <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// tb_seq_restoring_divider : vector table, handshake/reset sequences and random ops vs. arithmetic model.
// ============================================================================
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
    logic signed [W-1:0] sa, sb, sq, sr;
    dz = (b == '0);
    sa = a;
    sb = b;
    if (dz) begin
      q = '1;
      r = a;
    end else begin
`ifdef SIGNED_DIV_EN
      if (a == {1'b1, {(W-1){1'b0}}} && sb == -1) begin
        q = a;
        r = '0;
      end else begin
        sq = sa / sb;
        sr = sa % sb;
        q  = sq;
        r  = sr;
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Returns edges from accept until done is seen, and how many sampled cycles busy was high.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                       output int lat, output int bcyc);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    bcyc     = int'(busy);
    lat      = 0;
    while (lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      bcyc += int'(busy);
    end
    if (!done) chk("done_timeout", 0, 1);
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
  endtask

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dz;
    int           lat;
    int           bc;
  } vec_t;

  initial begin
    vec_t         tbl[$];
    logic [W-1:0] q, r, eq, er, a, b;
    logic         dz, edz;
    int           lat, bc, ndone;

`ifdef SIGNED_DIV_EN
    tbl.push_back('{4'd9,  4'd2,  4'd13, 4'd15, 1'b0, W + 1, W});
    tbl.push_back('{4'd7,  4'd14, 4'd13, 4'd1,  1'b0, W + 1, W});
    tbl.push_back('{4'd8,  4'd15, 4'd8,  4'd0,  1'b0, W + 1, W});
    tbl.push_back('{4'd10, 4'd3,  4'd14, 4'd0,  1'b0, W + 1, W});
    tbl.push_back('{4'd9,  4'd0,  4'd15, 4'd9,  1'b1, 1,     0});
    tbl.push_back('{4'd6,  4'd3,  4'd2,  4'd0,  1'b0, W + 1, W});
`else
    tbl.push_back('{4'd13, 4'd3,  4'd4,  4'd1,  1'b0, W + 1, W});
    tbl.push_back('{4'd15, 4'd1,  4'd15, 4'd0,  1'b0, W + 1, W});
    tbl.push_back('{4'd2,  4'd9,  4'd0,  4'd2,  1'b0, W + 1, W});
    tbl.push_back('{4'd15, 4'd15, 4'd1,  4'd0,  1'b0, W + 1, W});
    tbl.push_back('{4'd7,  4'd0,  4'd15, 4'd7,  1'b1, 1,     0});
    tbl.push_back('{4'd8,  4'd2,  4'd4,  4'd0,  1'b0, W + 1, W});
`endif

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, q, r, dz, lat, bc);
      chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_r", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_dz", i), dz, tbl[i].dz);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_busy_cycles", i), bc, tbl[i].bc);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_done_pulse", i), done, 0);
    end

    // start pulsed while busy must be ignored
    @(negedge clk);
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1; dividend = 4'd9; divisor = 4'd3;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0;
    q = '0; r = '0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        q = quotient;
        r = remainder;
      end
    end
    ref_div(4'd12, 4'd5, eq, er, edz);
    chk("busy_start_dones", ndone, 1);
    chk("busy_start_q", q, eq);
    chk("busy_start_r", r, er);

    // back-to-back: new start in the DONE-state cycle
    @(negedge clk);
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    chk("b2b_done_state_busy", busy, 0);
    chk("b2b_done_state_done", done, 0);
    start = 1'b1; dividend = 4'd9; divisor = 4'd3;
    @(posedge clk); #1; start = 1'b0;
    chk("b2b_first_done", done, 1);
    chk("b2b_first_q", quotient, eq);
    chk("b2b_first_r", remainder, er);
    chk("b2b_second_busy", busy, 1);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    ref_div(4'd9, 4'd3, eq, er, edz);
    chk("b2b_second_lat", lat, W + 1);
    chk("b2b_second_q", quotient, eq);
    chk("b2b_second_r", remainder, er);

    // reset in the second RUN cycle aborts the op
    @(posedge clk); #1;
    @(negedge clk);
    dividend = 4'd14; divisor = 4'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    ndone = 0;
    repeat (3) begin @(posedge clk); #1; ndone += int'(done); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; ndone += int'(done); end
    chk("abort_no_done", ndone, 0);
    do_op(4'd14, 4'd4, q, r, dz, lat, bc);
    ref_div(4'd14, 4'd4, eq, er, edz);
    chk("after_abort_q", q, eq);
    chk("after_abort_r", r, er);

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom_range(0, (1 << W) - 1));
      b = (i % 8 == 0) ? '0 : W'($urandom_range(0, (1 << W) - 1));
      do_op(a, b, q, r, dz, lat, bc);
      ref_div(a, b, eq, er, edz);
      chk($sformatf("rand%0d_%0d/%0d_q", i, a, b), q, eq);
      chk($sformatf("rand%0d_%0d/%0d_r", i, a, b), r, er);
      chk($sformatf("rand%0d_%0d/%0d_dz", i, a, b), dz, edz);
      chk($sformatf("rand%0d_lat", i), lat, edz ? 1 : W + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
